// File: rtl/button_scan_ctrl.sv
// Round-robin debounce scheduler: one shared timer serves a bank of buttons.
// Optional BUTTON_SCAN_TOGGLE_EN adds toggle_out, which flips on every committed press.
module button_scan_ctrl #(
  parameter int NB_BUTTONS      = 4,
  parameter int CLK_FREQ        = 95000,
  parameter int DEBOUNCE_PER_MS = 20,
  localparam int DEB_CYCLES     = CLK_FREQ * DEBOUNCE_PER_MS,
  localparam int IDX_W          = $clog2(NB_BUTTONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NB_BUTTONS-1:0] buttons_in,
  output logic [NB_BUTTONS-1:0] buttons_stable,
  output logic [NB_BUTTONS-1:0] press_pulse,
  output logic [NB_BUTTONS-1:0] release_pulse,
  output logic                  busy,
  output logic [IDX_W-1:0]      active_idx
`ifdef BUTTON_SCAN_TOGGLE_EN
  ,
  output logic [NB_BUTTONS-1:0] toggle_out
`endif
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BUTTONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   NB_W     = (IDX_W + 1)'(NB_BUTTONS);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        counter_reg;
  logic [IDX_W-1:0]        rr_ptr_reg;
  logic [NB_BUTTONS-1:0]   sync1_reg;
  logic [NB_BUTTONS-1:0]   s_in_reg;

  logic [NB_BUTTONS-1:0]   pending;
  logic [2*NB_BUTTONS-1:0] pend_dbl;
  logic [NB_BUTTONS-1:0]   pend_rot;
  logic [IDX_W-1:0]        sel_off;
  logic [IDX_W:0]          sel_sum;
  logic [IDX_W:0]          sel_wrap;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        next_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      s_in_reg  <= '0;
    end else begin
      sync1_reg <= buttons_in;
      s_in_reg  <= sync1_reg;
    end
  end

  assign pending = s_in_reg ^ buttons_stable;

  // Rotate pending so bit 0 is rr_ptr; the lowest set bit is then the round-robin winner.
  assign pend_dbl = {pending, pending} >> rr_ptr_reg;
  assign pend_rot = pend_dbl[NB_BUTTONS-1:0];

  always_comb begin
    sel_off = '0;
    for (int k = NB_BUTTONS - 1; k >= 0; k--) begin
      if (pend_rot[k]) sel_off = IDX_W'(k);
    end
  end

  assign sel_sum  = {1'b0, rr_ptr_reg} + {1'b0, sel_off};
  assign sel_wrap = (sel_sum >= NB_W) ? (sel_sum - NB_W) : sel_sum;
  assign sel_idx  = sel_wrap[IDX_W-1:0];
  assign next_ptr = (active_idx == LAST_IDX) ? '0 : (active_idx + IDX_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      rr_ptr_reg     <= '0;
      active_idx     <= '0;
      busy           <= 1'b0;
      buttons_stable <= '0;
      press_pulse    <= '0;
      release_pulse  <= '0;
`ifdef BUTTON_SCAN_TOGGLE_EN
      toggle_out     <= '0;
`endif
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      case (state_reg)
        IDLE: begin
          if (|pending) begin
            active_idx  <= sel_idx;
            counter_reg <= '0;
            state_reg   <= COUNT;
            busy        <= 1'b1;
          end
        end
        COUNT: begin
          if (s_in_reg[active_idx] == buttons_stable[active_idx]) begin
            // Input bounced back inside its window: drop the grant silently.
            rr_ptr_reg <= next_ptr;
            state_reg  <= IDLE;
            busy       <= 1'b0;
          end else if (counter_reg == CNT_LAST) begin
            buttons_stable[active_idx] <= ~buttons_stable[active_idx];
            if (!buttons_stable[active_idx]) begin
              press_pulse[active_idx] <= 1'b1;
`ifdef BUTTON_SCAN_TOGGLE_EN
              toggle_out[active_idx]  <= ~toggle_out[active_idx];
`endif
            end else begin
              release_pulse[active_idx] <= 1'b1;
            end
            rr_ptr_reg <= next_ptr;
            state_reg  <= IDLE;
            busy       <= 1'b0;
          end else begin
            counter_reg <= counter_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with a 4-cycle debounce window.
module tb_button_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] buttons_in;
  logic [3:0] buttons_stable;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       busy;
  logic [1:0] active_idx;
`ifdef BUTTON_SCAN_TOGGLE_EN
  logic [3:0] toggle_out;
`endif

  int checks = 0;
  int passed = 0;
  int failed = 0;

  button_scan_ctrl #(
    .NB_BUTTONS(4),
    .CLK_FREQ(1),
    .DEBOUNCE_PER_MS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .buttons_in(buttons_in),
    .buttons_stable(buttons_stable),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .busy(busy),
    .active_idx(active_idx)
`ifdef BUTTON_SCAN_TOGGLE_EN
    ,
    .toggle_out(toggle_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    buttons_in = 4'b1111;
    ticks(2);
    $display("[%0t] reset held with buttons=1111", $time);
    chk("rst_stable", buttons_stable, 4'b0000);
    chk("rst_press", press_pulse, 4'b0000);
    chk("rst_release", release_pulse, 4'b0000);
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_idx", 4'(active_idx), 4'd0);
    buttons_in = 4'b0000;
    rst_n      = 1'b1;
    ticks(3);

    // single press on bit0: grant at E0+2, commit at E0+6
    $display("[%0t] single press bit0", $time);
    buttons_in = 4'b0001;
    ticks(2);
    chk("t1_busy_e1", 4'(busy), 4'd0);
    ticks(1);
    chk("t1_busy_e2", 4'(busy), 4'd1);
    chk("t1_idx_e2", 4'(active_idx), 4'd0);
    ticks(3);
    chk("t1_stable_e5", buttons_stable, 4'b0000);
    chk("t1_busy_e5", 4'(busy), 4'd1);
    ticks(1);
    chk("t1_stable_e6", buttons_stable, 4'b0001);
    chk("t1_press_e6", press_pulse, 4'b0001);
    chk("t1_release_e6", release_pulse, 4'b0000);
    chk("t1_busy_e6", 4'(busy), 4'd0);
    ticks(1);
    chk("t1_press_e7", press_pulse, 4'b0000);

    // bit1 bounces: high for three sampled edges, abort at E0+5
    $display("[%0t] bounce on bit1", $time);
    buttons_in = 4'b0011;
    ticks(3);
    chk("t2_busy_e2", 4'(busy), 4'd1);
    chk("t2_idx_e2", 4'(active_idx), 4'd1);
    buttons_in = 4'b0001;
    ticks(2);
    chk("t2_busy_e4", 4'(busy), 4'd1);
    ticks(1);
    chk("t2_busy_e5", 4'(busy), 4'd0);
    chk("t2_press_e5", press_pulse, 4'b0000);
    chk("t2_stable_e5", buttons_stable, 4'b0001);
    ticks(1);
    chk("t2_press_e6", press_pulse, 4'b0000);
    chk("t2_stable_e6", buttons_stable, 4'b0001);

    // rr_ptr is now 2: with bits 1 and 3 pending, bit3 wins first
    $display("[%0t] round-robin from rr_ptr=2", $time);
    buttons_in = 4'b1011;
    ticks(3);
    chk("t2rr_idx_first", 4'(active_idx), 4'd3);
    ticks(4);
    chk("t2rr_press_b3", press_pulse, 4'b1000);
    chk("t2rr_stable_b3", buttons_stable, 4'b1001);
    ticks(1);
    chk("t2rr_busy_second", 4'(busy), 4'd1);
    chk("t2rr_idx_second", 4'(active_idx), 4'd1);
    ticks(4);
    chk("t2rr_press_b1", press_pulse, 4'b0010);
    chk("t2rr_stable_b1", buttons_stable, 4'b1011);
    ticks(1);

    $display("[%0t] reset between tests", $time);
    buttons_in = 4'b0000;
    rst_n      = 1'b0;
    #1;
    chk("rst2_stable_async", buttons_stable, 4'b0000);
    ticks(1);
    rst_n = 1'b1;
    ticks(2);

    // bits 0 and 2 together from rr_ptr=0
    $display("[%0t] simultaneous bits 0 and 2", $time);
    buttons_in = 4'b0101;
    ticks(3);
    chk("t3_idx_first", 4'(active_idx), 4'd0);
    ticks(4);
    chk("t3_press_b0", press_pulse, 4'b0001);
    ticks(1);
    chk("t3_idx_second", 4'(active_idx), 4'd2);
    chk("t3_press_gap", press_pulse, 4'b0000);
    ticks(4);
    chk("t3_press_b2", press_pulse, 4'b0100);
    chk("t3_release_b2", release_pulse, 4'b0000);
    chk("t3_stable", buttons_stable, 4'b0101);
    ticks(1);

    // release of bit0 (rr_ptr=3 wraps to bit0), leaves rr_ptr=1
    $display("[%0t] release bit0", $time);
    buttons_in = 4'b0100;
    ticks(3);
    chk("t4_rel_idx", 4'(active_idx), 4'd0);
    ticks(4);
    chk("t4_release", release_pulse, 4'b0001);
    chk("t4_rel_press", press_pulse, 4'b0000);
    chk("t4_rel_stable", buttons_stable, 4'b0100);
    ticks(1);

    $display("[%0t] round-robin from rr_ptr=1 with bits 0 and 3", $time);
    buttons_in = 4'b1101;
    ticks(3);
    chk("t4_idx_first", 4'(active_idx), 4'd3);
    ticks(4);
    chk("t4_press_b3", press_pulse, 4'b1000);
    ticks(1);
    chk("t4_idx_second", 4'(active_idx), 4'd0);
    ticks(4);
    chk("t4_press_b0", press_pulse, 4'b0001);
    chk("t4_stable", buttons_stable, 4'b1101);
    ticks(1);

    // reset while bit1 is mid-window (counter=2)
    $display("[%0t] reset mid-count", $time);
    buttons_in = 4'b1111;
    ticks(3);
    chk("t5_idx_grant", 4'(active_idx), 4'd1);
    ticks(2);
    chk("t5_busy_pre", 4'(busy), 4'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 4'(busy), 4'd0);
    chk("t5_stable_rst", buttons_stable, 4'b0000);
    chk("t5_press_rst", press_pulse, 4'b0000);
    chk("t5_idx_rst", 4'(active_idx), 4'd0);
    ticks(1);
    rst_n = 1'b1;
    ticks(3);
    chk("t5_busy_regrant", 4'(busy), 4'd1);
    chk("t5_idx_regrant", 4'(active_idx), 4'd0);
    ticks(3);
    chk("t5_stable_e5", buttons_stable, 4'b0000);
    ticks(1);
    chk("t5_stable_e6", buttons_stable, 4'b0001);
    chk("t5_press_e6", press_pulse, 4'b0001);

`ifdef BUTTON_SCAN_TOGGLE_EN
    buttons_in = 4'b0000;
    rst_n      = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    ticks(2);
    $display("[%0t] toggle press/release/press on bit0", $time);
    chk("t6_toggle_rst", toggle_out, 4'b0000);
    buttons_in = 4'b0001;
    ticks(6);
    chk("t6_toggle_pre1", toggle_out, 4'b0000);
    ticks(1);
    chk("t6_toggle_p1", toggle_out, 4'b0001);
    chk("t6_press_p1", press_pulse, 4'b0001);
    ticks(1);
    buttons_in = 4'b0000;
    ticks(7);
    chk("t6_release_r", release_pulse, 4'b0001);
    chk("t6_toggle_r", toggle_out, 4'b0001);
    ticks(1);
    buttons_in = 4'b0001;
    ticks(6);
    chk("t6_toggle_pre2", toggle_out, 4'b0001);
    ticks(1);
    chk("t6_toggle_p2", toggle_out, 4'b0000);
    chk("t6_press_p2", press_pulse, 4'b0001);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_scan_ctrl.md
Name: button_scan_ctrl

Overview:
- Debounce scheduler for a bank of push-buttons that share one debounce timer.
- Watches all synchronized button inputs and grants the single timer to one pending button at a time, in round-robin order.
- Commits a level change only if the input holds for the full debounce window, then emits one-cycle press/release events.
- Sits between the raw board button pins and the user-interface logic. Replaces per-button debounce counters on large button banks.

Parameters:
- NB_BUTTONS, 4, number of buttons; legal range 2..16.
- CLK_FREQ, 95000, clock frequency in kHz.
- DEBOUNCE_PER_MS, 20, debounce window in ms.
- localparam DEB_CYCLES = CLK_FREQ*DEBOUNCE_PER_MS (must be >= 1).
- localparam IDX_W = clog2(NB_BUTTONS).
- Counter width is sized to hold DEB_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- buttons_in  in  NB_BUTTONS  raw asynchronous button levels, active-high.
- buttons_stable  out  NB_BUTTONS  debounced levels.
- press_pulse  out  NB_BUTTONS  one-cycle pulse per committed 0->1.
- release_pulse  out  NB_BUTTONS  one-cycle pulse per committed 1->0.
- busy  out  1  high while the timer is granted (state COUNT).
- active_idx  out  IDX_W  index of the granted button; holds its last value when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sync flops, stable, pulses, busy, active_idx, counter, rr_ptr all cleared to 0.
  - state = IDLE.
- Synchronizer: two-flop synchronizer per bit, giving s_in. s_in is the only input view used.
- pending = s_in XOR stable.
- IDLE:
  - If pending != 0, select the first set bit of pending searching upward from rr_ptr, wrapping modulo NB_BUTTONS.
  - Load active_idx with that bit, clear the counter, go to COUNT.
  - Else stay in IDLE.
- COUNT, each cycle, in priority order:
  - (a) If s_in[active_idx] == stable[active_idx]: abort. Go to IDLE, rr_ptr = active_idx+1 mod NB, no pulse.
  - (b) Else if counter == DEB_CYCLES-1: commit. stable[active_idx] toggles; press_pulse[active_idx] asserts if the new value is 1, else release_pulse[active_idx] asserts. rr_ptr = active_idx+1 mod NB. Go to IDLE.
  - (c) Else counter increments.
- Latency: for a clean input level first sampled at edge E0, stable and the pulse update at edge E0+DEB_CYCLES+2.
- Pulses are registered, exactly one cycle wide. At most one bit across press_pulse|release_pulse is set in any cycle.
- Changes on non-granted buttons during COUNT are not lost. They remain in pending and are served after the grant is released. Each grant release costs one IDLE cycle.
- A button that bounces back during its own window aborts; if it later changes again it re-enters arbitration.
- Fairness: a continuously pending button waits at most NB_BUTTONS-1 grants.
- Reset mid-COUNT: the grant is dropped immediately, no pulse is produced, and stable returns to 0.
- busy = (state == COUNT), registered with the state.

Optional Feature:
- Macro: BUTTON_SCAN_TOGGLE_EN.
- Defined: adds output port toggle_out [NB_BUTTONS], reset 0. toggle_out[i] inverts in the same cycle press_pulse[i] is asserted; release has no effect.
- Undefined: the port and its flops are absent. All other behaviour is identical.

Test Plan:
(All with NB_BUTTONS=4, CLK_FREQ=1, DEBOUNCE_PER_MS=4, so DEB_CYCLES=4.)
1. Reset and single press:
   - Hold rst_n=0 with buttons_in=4'b1111 -> all outputs 0.
   - Release reset, then set buttons_in=4'b0001 sampled at E0 -> busy=1 from E0+2, active_idx=0.
   - At E0+6: stable=4'b0001 and press_pulse=4'b0001 for exactly 1 cycle, busy=0.
2. Bounce:
   - bit1 high for 3 cycles, then low -> abort, no pulses, stable unchanged, busy falls.
   - Next grant starts from rr_ptr=2.
3. Simultaneous:
   - bits 0 and 2 rise at E0 with rr_ptr=0 -> press_pulse=0001 at E0+6, then press_pulse=0100 at E0+11.
   - Final stable=0101.
4. Round-robin and release:
   - With rr_ptr=1, bits 0 and 3 both pending -> bit 3 is served first, then bit 0.
   - A falling bit0 gives release_pulse=0001 and stable bit0=0.
5. Reset mid-operation:
   - Drop rst_n for 1 cycle at counter=2 -> busy=0 immediately, no pulse, stable=0.
   - After reset, a held input re-debounces the full window (DEB_CYCLES+2 edges).
6. BUTTON_SCAN_TOGGLE_EN defined:
   - Press/release/press on bit0 -> toggle_out[0] goes 0 -> 1 -> 1 -> 0.
   - Changes occur only with press_pulse[0].
